// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - MIPS MEM stage: req/ack data-memory access, redirect, forwarding probe, MEM/WB register
module mem_stage #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic        is_branch,
  input  logic [31:0] pc_branch,
  input  logic        alu_zero,
  input  logic        is_jump,
  input  logic [31:0] pc_jump,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic        mem_type,
  input  logic        mem_to_reg,
  input  logic [31:0] alu_out,
  input  logic [31:0] data_t,
  input  logic [4:0]  reg_addr,
  input  logic        reg_write,
  output logic        pc_src,
  output logic [31:0] pc_target,
  output logic        mem_busy,
  output logic        mem_error,
  output logic [4:0]  reg_probe,
  output logic [31:0] data_probe,
  output logic        write_probe,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] mem_data_out,
  output logic [31:0] alu_out_wb,
  output logic [4:0]  reg_addr_out,
  output logic        reg_write_out,
  output logic        mem_to_reg_out
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Counter compare value; the counter is 8 bits wide so TIMEOUT must be 1..255.
  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;

  logic        dmem_req_q, dmem_req_d;
  logic        dmem_we_q, dmem_we_d;
  logic [31:0] dmem_addr_q, dmem_addr_d;
  logic [31:0] dmem_wdata_q, dmem_wdata_d;
  logic [3:0]  dmem_be_q, dmem_be_d;
  logic        mem_error_q, mem_error_d;

  logic [31:0] mem_data_out_q, mem_data_out_d;
  logic [31:0] alu_out_wb_q, alu_out_wb_d;
  logic [4:0]  reg_addr_out_q, reg_addr_out_d;
  logic        reg_write_out_q, reg_write_out_d;
  logic        mem_to_reg_out_q, mem_to_reg_out_d;

  logic        is_access;
  logic        misaligned;
  logic [7:0]  cnt_inc;
  logic [3:0]  lane_be;
  logic        bus_we;
  logic [3:0]  bus_be;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [7:0]  load_byte;
  logic [31:0] load_fmt;
  logic        load_wb;

  // Redirect and forwarding probe are pure functions of the EX/MEM inputs.
  always_comb begin
    pc_src      = (is_branch & alu_zero) | is_jump;
    pc_target   = is_jump ? pc_jump : pc_branch;
    reg_probe   = reg_addr;
    data_probe  = alu_out;
    write_probe = reg_write & ~mem_to_reg;
  end

  // Bus request contents derived from the current instruction; byte stores replicate into every lane.
  always_comb begin
    is_access  = mem_read | mem_write;
    misaligned = ~mem_type & (alu_out[1:0] != 2'b00);
    cnt_inc    = cnt_q + 8'd1;
    lane_be    = 4'b0001 << alu_out[1:0];
    bus_we     = mem_write;
    bus_be     = mem_type ? lane_be : 4'b1111;
    bus_addr   = {alu_out[31:2], 2'b00};
    bus_wdata  = mem_type ? {4{data_t[7:0]}} : data_t;
  end

  // Stall while a fresh access is seen in IDLE or the bus is still open.
  always_comb begin
    mem_busy = 1'b0;
    case (state_q)
      S_IDLE:  mem_busy = is_access;
      S_BUS:   mem_busy = 1'b1;
      S_DONE:  mem_busy = 1'b0;
      default: mem_busy = 1'b0;
    endcase
  end

  // Next state, timeout counter, captured read data and the registered bus outputs.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    rdata_d      = rdata_q;
    dmem_req_d   = 1'b0;
    dmem_we_d    = 1'b0;
    dmem_be_d    = 4'b0000;
    dmem_addr_d  = dmem_addr_q;
    dmem_wdata_d = dmem_wdata_q;
    mem_error_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (is_access) begin
          if (misaligned) begin
            // Misaligned word: never reaches the bus, finishes like a timeout.
            state_d     = S_DONE;
            rdata_d     = 32'd0;
            mem_error_d = 1'b1;
          end else begin
            state_d      = S_BUS;
            cnt_d        = 8'd0;
            dmem_req_d   = 1'b1;
            dmem_we_d    = bus_we;
            dmem_be_d    = bus_be;
            dmem_addr_d  = bus_addr;
            dmem_wdata_d = bus_wdata;
          end
        end
      end
      S_BUS: begin
        if (dmem_ack) begin
          // Ack is checked first so it wins over a coincident timeout.
          state_d = S_DONE;
          rdata_d = dmem_rdata;
          cnt_d   = 8'd0;
        end else if (cnt_inc == TIMEOUT_C) begin
          state_d     = S_DONE;
          rdata_d     = 32'd0;
          cnt_d       = 8'd0;
          mem_error_d = 1'b1;
        end else begin
          cnt_d        = cnt_inc;
          dmem_req_d   = 1'b1;
          dmem_we_d    = bus_we;
          dmem_be_d    = bus_be;
          dmem_addr_d  = bus_addr;
          dmem_wdata_d = bus_wdata;
        end
      end
      S_DONE: begin
        if (we) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 8'd0;
      end
    endcase
  end

  // FSM and bus-side registers; reset drops the request immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= 8'd0;
      rdata_q      <= 32'd0;
      dmem_req_q   <= 1'b0;
      dmem_we_q    <= 1'b0;
      dmem_be_q    <= 4'b0000;
      dmem_addr_q  <= 32'd0;
      dmem_wdata_q <= 32'd0;
      mem_error_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rdata_q      <= rdata_d;
      dmem_req_q   <= dmem_req_d;
      dmem_we_q    <= dmem_we_d;
      dmem_be_q    <= dmem_be_d;
      dmem_addr_q  <= dmem_addr_d;
      dmem_wdata_q <= dmem_wdata_d;
      mem_error_q  <= mem_error_d;
    end
  end

  // Load formatting from captured data: word as-is, byte lane sign-extended, stores yield zero.
  always_comb begin
    load_byte = 8'd0;
    case (alu_out[1:0])
      2'd0:    load_byte = rdata_q[7:0];
      2'd1:    load_byte = rdata_q[15:8];
      2'd2:    load_byte = rdata_q[23:16];
      2'd3:    load_byte = rdata_q[31:24];
      default: load_byte = 8'd0;
    endcase
    if (mem_write || !mem_read) begin
      load_fmt = 32'd0;
    end else if (mem_type) begin
      load_fmt = {{24{load_byte[7]}}, load_byte};
    end else begin
      load_fmt = rdata_q;
    end
  end

  // MEM/WB register advances only when the hazard unit allows it and no access is in flight.
  always_comb begin
    load_wb          = we & ~mem_busy;
    mem_data_out_d   = mem_data_out_q;
    alu_out_wb_d     = alu_out_wb_q;
    reg_addr_out_d   = reg_addr_out_q;
    reg_write_out_d  = reg_write_out_q;
    mem_to_reg_out_d = mem_to_reg_out_q;
    if (load_wb) begin
      mem_data_out_d   = load_fmt;
      alu_out_wb_d     = alu_out;
      reg_addr_out_d   = reg_addr;
      reg_write_out_d  = reg_write;
      mem_to_reg_out_d = mem_to_reg;
    end
  end

  // MEM/WB pipeline register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_data_out_q   <= 32'd0;
      alu_out_wb_q     <= 32'd0;
      reg_addr_out_q   <= 5'd0;
      reg_write_out_q  <= 1'b0;
      mem_to_reg_out_q <= 1'b0;
    end else begin
      mem_data_out_q   <= mem_data_out_d;
      alu_out_wb_q     <= alu_out_wb_d;
      reg_addr_out_q   <= reg_addr_out_d;
      reg_write_out_q  <= reg_write_out_d;
      mem_to_reg_out_q <= mem_to_reg_out_d;
    end
  end

  // Registered outputs to ports.
  always_comb begin
    dmem_req       = dmem_req_q;
    dmem_we        = dmem_we_q;
    dmem_addr      = dmem_addr_q;
    dmem_wdata     = dmem_wdata_q;
    dmem_be        = dmem_be_q;
    mem_error      = mem_error_q;
    mem_data_out   = mem_data_out_q;
    alu_out_wb     = alu_out_wb_q;
    reg_addr_out   = reg_addr_out_q;
    reg_write_out  = reg_write_out_q;
    mem_to_reg_out = mem_to_reg_out_q;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- MEM stage of the 5-stage MIPS pipeline. Consumes the EX/MEM register outputs and performs loads and stores on a req/ack data-memory bus.
- Stalls the pipeline while an access is outstanding.
- Resolves branch/jump redirect for fetch and loads the MEM/WB pipeline register.
- Provides a forwarding probe for the hazard unit.

Parameters:
TIMEOUT, 255, max BUS-state cycles without dmem_ack before the access is aborted (8-bit counter, 1..255)

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
we  in  1  MEM/WB register write enable from hazard unit
is_branch  in  1  EX/MEM: conditional branch
pc_branch  in  32  EX/MEM: branch target
alu_zero  in  1  EX/MEM: ALU zero flag
is_jump  in  1  EX/MEM: jump
pc_jump  in  32  EX/MEM: jump target
mem_read  in  1  EX/MEM: load
mem_write  in  1  EX/MEM: store
mem_type  in  1  EX/MEM: 0=word, 1=byte
mem_to_reg  in  1  EX/MEM: WB selects memory data
alu_out  in  32  EX/MEM: address / ALU result
data_t  in  32  EX/MEM: store data
reg_addr  in  5  EX/MEM: destination register
reg_write  in  1  EX/MEM: register write
pc_src  out  1  redirect fetch (combinational)
pc_target  out  32  redirect target (combinational)
mem_busy  out  1  stall request (combinational)
mem_error  out  1  one-cycle pulse: misaligned word access or timeout
reg_probe  out  5  forward: reg_addr
data_probe  out  32  forward: alu_out
write_probe  out  1  forward: reg_write & ~mem_to_reg
dmem_req  out  1  bus request
dmem_we  out  1  bus write
dmem_addr  out  32  word-aligned address {alu_out[31:2],2'b00}
dmem_wdata  out  32  write data
dmem_be  out  4  byte enables
dmem_ack  in  1  bus acknowledge
dmem_rdata  in  32  bus read data, valid with ack
mem_data_out  out  32  MEM/WB: load result
alu_out_wb  out  32  MEM/WB: ALU result
reg_addr_out  out  5  MEM/WB: destination
reg_write_out  out  1  MEM/WB: write enable
mem_to_reg_out  out  1  MEM/WB: data select

Behaviour:
- Reset (async): state IDLE, timeout counter 0, rdata_q 0. dmem_req, dmem_we, mem_error, and all MEM/WB outputs are 0. dmem_be is 0.
- pc_src = (is_branch & alu_zero) | is_jump. pc_target = is_jump ? pc_jump : pc_branch.
- Access pending = (mem_read | mem_write) while state is IDLE.
- Misaligned = ~mem_type & (alu_out[1:0] != 0). A misaligned access issues no bus request and is handled like a timeout: DONE with data 0 and mem_error pulse.
- FSM states IDLE, BUS, DONE.
  - IDLE: if access pending, mem_busy=1. Go to BUS, or to DONE with a mem_error pulse if misaligned. Otherwise mem_busy=0.
  - BUS: dmem_req=1, mem_busy=1.
    - dmem_we = mem_write.
    - Word: be=4'b1111, wdata=data_t.
    - Byte: be = one-hot lane alu_out[1:0] (little-endian, lane0 = bits 7:0), wdata = data_t[7:0] replicated to all four lanes.
    - On dmem_ack: capture dmem_rdata into rdata_q and go to DONE.
    - Otherwise the counter increments. When it reaches TIMEOUT: rdata_q=0, mem_error pulse, go to DONE.
    - If ack and timeout occur in the same cycle, ack wins.
  - DONE: mem_busy=0, dmem_req=0. If we=1, go to IDLE; if we=0, stay in DONE.
- Bus signals are registered from the FSM. dmem_req is deasserted the cycle after ack.
- Load data formatting from rdata_q:
  - word: as-is.
  - byte: selected lane, sign-extended to 32 bits.
  - Stores produce mem_data_out = 0.
- MEM/WB register on clk when we=1 and mem_busy=0: mem_data_out, alu_out_wb=alu_out, reg_addr_out, reg_write_out, mem_to_reg_out load from the current inputs. Otherwise all outputs hold.
- Non-memory instructions pass through with zero stall cycles.
- Memory-access latency: best case 3 cycles (IDLE, BUS with ack, DONE).
- dmem_ack outside BUS is ignored.
- Reset mid-BUS drops dmem_req asynchronously; a late ack arriving after reset is ignored.
- Simultaneous mem_read & mem_write is treated as a store.

Test Plan:
- ALU op: reg_write=1, alu_out=0x1234, reg_addr=5, we=1 -> next edge alu_out_wb=0x1234, reg_addr_out=5, mem_busy never 1. write_probe=1, data_probe=0x1234.
- lw at 0x100, ack in the 2nd BUS cycle with rdata=0xDEADBEEF -> dmem_addr=0x100, be=1111. mem_busy=1 for 3 cycles. mem_data_out=0xDEADBEEF.
- lb at 0x103 with rdata=0x80FF0011 -> be=1000 during BUS, mem_data_out=0xFFFFFF80. sb at 0x101, data_t=0x000000AB -> wdata=0xABABABAB, be=0010, dmem_we=1.
- lw at 0x102 -> no dmem_req, mem_error pulses for 1 cycle, mem_data_out=0. Pipeline resumes.
- TIMEOUT=4 with ack never asserted -> req high for 4 cycles, then mem_error pulse and mem_data_out=0. Assert reset during BUS -> dmem_req=0 immediately, all outputs 0.
- is_branch=1, alu_zero=1, pc_branch=0x40 -> pc_src=1, pc_target=0x40. is_jump=1, pc_jump=0x80 -> pc_target=0x80.
